// File: rtl/ext_dispatch_pkg.sv
// Shared definitions for the extension dispatch controller: FSM state
// encoding, fault codes and the first custom-handler function number.
package ext_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WB    = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // Functions below this number go to the built-in unit; custom handler n
    // (n = 0..NUM_CUSTOM-1) owns function EXT_FUNC_CUSTOM_BASE + n.
    localparam int EXT_FUNC_CUSTOM_BASE = 7;

endpackage

// File: rtl/ext_func_decoder.sv
// Combinational decode of an extension function number into a one-hot unit
// select and an illegal-function flag.
//   func    : extension function (4 bits)
//   sel     : one-hot unit select; bit 0 = built-in, bit n = custom n-1
//   illegal : func maps to no unit (sel is all zeros)
module ext_func_decoder
    import ext_dispatch_pkg::*;
#(
    parameter int NUM_CUSTOM    = 3,
    parameter int BUILTIN_FUNCS = EXT_FUNC_CUSTOM_BASE
) (
    input  logic [3:0]          func,
    output logic [NUM_CUSTOM:0] sel,
    output logic                illegal
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        sel = '0;
        if (int'(func) < BUILTIN_FUNCS) begin
            sel[0] = 1'b1;
        end
        for (int i = 0; i < NUM_CUSTOM; i++) begin
            if (int'(func) == BUILTIN_FUNCS + i) begin
                sel[i + 1] = 1'b1;
            end
        end
        illegal = (sel == '0);
    end

endmodule

// File: rtl/extension_dispatch_controller.sv
// Sequences one extension instruction at a time from the core to the built-in
// unit or a custom handler over a req/ack handshake, stalls the core while
// busy, writes the result back and reports illegal functions and timeouts.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   issue_valid/ready/func/dst/opa/opb : instruction issue from the core
//   flush                     : abort the current instruction
//   unit_req/func/opa/opb     : one-hot request and latched operands to units
//   unit_ack, unit_result     : per-unit completion and packed results
//   wb_en/addr/data           : one-cycle register-file write
//   stall                     : hold the core pipeline (state != IDLE)
//   fault, fault_code         : fault pulse and sticky fault cause
//   ext_count                 : completed instructions, wraps at 0xFFFF
module extension_dispatch_controller
    import ext_dispatch_pkg::*;
#(
    parameter int NUM_CUSTOM    = 3,
    parameter int BUILTIN_FUNCS = EXT_FUNC_CUSTOM_BASE,
    parameter int TIMEOUT       = 15,
    parameter int DATA_W        = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid,
    output logic                             issue_ready,
    input  logic [3:0]                       issue_func,
    input  logic [2:0]                       issue_dst,
    input  logic [DATA_W-1:0]                issue_opa,
    input  logic [DATA_W-1:0]                issue_opb,
    input  logic                             flush,
    output logic [NUM_CUSTOM:0]              unit_req,
    output logic [3:0]                       unit_func,
    output logic [DATA_W-1:0]                unit_opa,
    output logic [DATA_W-1:0]                unit_opb,
    input  logic [NUM_CUSTOM:0]              unit_ack,
    input  logic [(NUM_CUSTOM+1)*DATA_W-1:0] unit_result,
    output logic                             wb_en,
    output logic [2:0]                       wb_addr,
    output logic [DATA_W-1:0]                wb_data,
    output logic                             stall,
    output logic                             fault,
    output logic [1:0]                       fault_code,
    output logic [15:0]                      ext_count
);

    state_t              state;
    logic [2:0]          dst_q;
    logic [7:0]          timer;
    logic [NUM_CUSTOM:0] dec_sel;
    logic                dec_illegal;
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_result;

    ext_func_decoder #(
        .NUM_CUSTOM    (NUM_CUSTOM),
        .BUILTIN_FUNCS (BUILTIN_FUNCS)
    ) u_decoder (
        .func    (issue_func),
        .sel     (dec_sel),
        .illegal (dec_illegal)
    );

    // unit_req is one-hot while in REQ, so it masks out acks and results
    // from units that were not selected.
    assign sel_ack = |(unit_ack & unit_req);

    always_comb begin
        sel_result = '0;
        for (int n = 0; n <= NUM_CUSTOM; n++) begin
            if (unit_req[n]) begin
                sel_result = unit_result[n*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            issue_ready <= 1'b1;
            stall       <= 1'b0;
            unit_req    <= '0;
            unit_func   <= '0;
            unit_opa    <= '0;
            unit_opb    <= '0;
            dst_q       <= '0;
            timer       <= '0;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            fault       <= 1'b0;
            fault_code  <= FAULT_NONE;
            ext_count   <= '0;
        end else begin
            // wb_en and fault are single-cycle pulses.
            wb_en <= 1'b0;
            fault <= 1'b0;

            if (flush) begin
                // Abort from any state; fault_code keeps its last cause.
                state       <= ST_IDLE;
                issue_ready <= 1'b1;
                stall       <= 1'b0;
                unit_req    <= '0;
                timer       <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (issue_valid) begin
                            unit_func   <= issue_func;
                            unit_opa    <= issue_opa;
                            unit_opb    <= issue_opb;
                            dst_q       <= issue_dst;
                            timer       <= '0;
                            issue_ready <= 1'b0;
                            stall       <= 1'b1;
                            if (dec_illegal) begin
                                state      <= ST_FAULT;
                                fault      <= 1'b1;
                                fault_code <= FAULT_ILLEGAL;
                            end else begin
                                state    <= ST_REQ;
                                unit_req <= dec_sel;
                            end
                        end
                    end
                    ST_REQ: begin
                        // Ack is tested first so it wins over a coinciding timeout.
                        if (sel_ack) begin
                            state     <= ST_WB;
                            unit_req  <= '0;
                            timer     <= '0;
                            wb_en     <= 1'b1;
                            wb_addr   <= dst_q;
                            wb_data   <= sel_result;
                            ext_count <= ext_count + 16'd1;
                        end else if (timer == 8'(TIMEOUT - 1)) begin
                            state      <= ST_FAULT;
                            unit_req   <= '0;
                            timer      <= '0;
                            fault      <= 1'b1;
                            fault_code <= FAULT_TIMEOUT;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                    ST_WB, ST_FAULT: begin
                        state       <= ST_IDLE;
                        issue_ready <= 1'b1;
                        stall       <= 1'b0;
                    end
                    default: begin
                        state       <= ST_IDLE;
                        issue_ready <= 1'b1;
                        stall       <= 1'b0;
                        unit_req    <= '0;
                    end
                endcase
            end
        end
    end

endmodule
